// File: rtl/regfile_write_bank.sv
// Write side of the register file: 5-to-32 write-enable decoder, enable-gated
// register bank exposed as one packed array, write-done pulse and write counter.
module regfile_write_bank #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 31,
    parameter bit          ZERO_EN  = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RegWrite,
    input  logic [$clog2(DEPTH)-1:0]     WriteRegister,
    input  logic [WIDTH-1:0]             WriteData,
    output logic [DEPTH-1:0][WIDTH-1:0]  regs,
    output logic [DEPTH-1:0]             wr_en_onehot,
    output logic                         wr_done,
    output logic [15:0]                  write_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic        w_any_write;
    logic        r_wr_done;
    logic [15:0] r_write_count;

    // RegWrite gates every term, so an unknown address while idle cannot enable a write.
    always_comb begin
        wr_en_onehot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!(ZERO_EN && (i == ZERO_REG))) begin
                wr_en_onehot[i] = RegWrite && (WriteRegister == AW'(i));
            end
        end
    end

    assign w_any_write = |wr_en_onehot;

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        if (ZERO_EN && (g == ZERO_REG)) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (wr_en_onehot[g]) begin
                    r_q <= WriteData;
                end
            end
            assign regs[g] = r_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_done     <= 1'b0;
            r_write_count <= '0;
        end else begin
            r_wr_done <= w_any_write;
            if (w_any_write) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

    assign wr_done     = r_wr_done;
    assign write_count = r_write_count;

endmodule
